// File: rtl/riscv_bus_arbiter.sv
// Arbitrates one memory slave port between instruction fetch and data access.
// One outstanding transaction; data has priority unless fetch has lost STARVE_LIMIT times in a row.
module riscv_bus_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int AW           = 32,
    parameter int DW           = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_instr_req,
    input  logic [AW-1:0]   i_instr_addr,
    output logic            o_instr_gnt,
    output logic            o_instr_rvalid,
    output logic [DW-1:0]   o_instr_rdata,
    input  logic            i_data_req,
    input  logic            i_data_we,
    input  logic [DW/8-1:0] i_data_be,
    input  logic [AW-1:0]   i_data_addr,
    input  logic [DW-1:0]   i_data_wdata,
    output logic            o_data_gnt,
    output logic            o_data_rvalid,
    output logic [DW-1:0]   o_data_rdata,
    output logic            o_s_req,
    output logic            o_s_we,
    output logic [DW/8-1:0] o_s_be,
    output logic [AW-1:0]   o_s_addr,
    output logic [DW-1:0]   o_s_wdata,
    input  logic            i_s_gnt,
    input  logic            i_s_rvalid,
    input  logic [DW-1:0]   i_s_rdata,
    output logic            o_owner,
    output logic            o_busy
);
    localparam int BW = DW / 8;
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t          state;
    logic            owner;
    logic [3:0]      starve_cnt;
    logic            lat_we;
    logic [BW-1:0]   lat_be;
    logic [AW-1:0]   lat_addr;
    logic [DW-1:0]   lat_wdata;

    logic            any_req;
    logic            data_wins;
    logic            win_we;
    logic [BW-1:0]   win_be;
    logic [AW-1:0]   win_addr;
    logic [DW-1:0]   win_wdata;

    // Data wins unless fetch is pending and has already lost LIMIT times.
    assign any_req   = i_instr_req | i_data_req;
    assign data_wins = i_data_req & ((starve_cnt < LIMIT) | ~i_instr_req);
    assign win_we    = data_wins ? i_data_we    : 1'b0;
    assign win_be    = data_wins ? i_data_be    : {BW{1'b1}};
    assign win_addr  = data_wins ? i_data_addr  : i_instr_addr;
    assign win_wdata = data_wins ? i_data_wdata : '0;

    assign o_owner = owner;
    assign o_busy  = (state != IDLE);

    always_comb begin
        o_s_req        = 1'b0;
        o_s_we         = 1'b0;
        o_s_be         = '0;
        o_s_addr       = '0;
        o_s_wdata      = '0;
        o_instr_gnt    = 1'b0;
        o_data_gnt     = 1'b0;
        o_instr_rvalid = 1'b0;
        o_instr_rdata  = '0;
        o_data_rvalid  = 1'b0;
        o_data_rdata   = '0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    o_s_req     = 1'b1;
                    o_s_we      = win_we;
                    o_s_be      = win_be;
                    o_s_addr    = win_addr;
                    o_s_wdata   = win_wdata;
                    o_data_gnt  = i_s_gnt & data_wins;
                    o_instr_gnt = i_s_gnt & ~data_wins;
                end
            end
            REQ: begin
                // Slave sees the fields captured at arbitration, even if the master drops req.
                o_s_req     = 1'b1;
                o_s_we      = lat_we;
                o_s_be      = lat_be;
                o_s_addr    = lat_addr;
                o_s_wdata   = lat_wdata;
                o_data_gnt  = i_s_gnt & owner;
                o_instr_gnt = i_s_gnt & ~owner;
            end
            RESP: begin
                if (i_s_rvalid) begin
                    if (owner) begin
                        o_data_rvalid = 1'b1;
                        o_data_rdata  = i_s_rdata;
                    end else begin
                        o_instr_rvalid = 1'b1;
                        o_instr_rdata  = i_s_rdata;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= 1'b0;
            starve_cnt <= '0;
            lat_we     <= 1'b0;
            lat_be     <= '0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner     <= data_wins;
                        lat_we    <= win_we;
                        lat_be    <= win_be;
                        lat_addr  <= win_addr;
                        lat_wdata <= win_wdata;
                        state     <= i_s_gnt ? RESP : REQ;
                        if (data_wins && i_instr_req && (starve_cnt < LIMIT))
                            starve_cnt <= starve_cnt + 4'd1;
                        else if (!data_wins && i_s_gnt)
                            starve_cnt <= '0;
                    end
                end
                REQ: begin
                    if (i_s_gnt) begin
                        state <= RESP;
                        if (!owner) starve_cnt <= '0;
                    end
                end
                RESP: begin
                    if (i_s_rvalid) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_riscv_bus_arbiter.sv
// Bench for riscv_bus_arbiter: directed scenarios plus random traffic checked
// every cycle against a transaction-level model of the arbitration rules.
module tb_riscv_bus_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          instr_req = 1'b0;
    logic [31:0]   instr_addr = '0;
    logic          instr_gnt, instr_rvalid;
    logic [31:0]   instr_rdata;
    logic          data_req = 1'b0, data_we = 1'b0;
    logic [3:0]    data_be = '0;
    logic [31:0]   data_addr = '0, data_wdata = '0;
    logic          data_gnt, data_rvalid;
    logic [31:0]   data_rdata;
    logic          s_req, s_we;
    logic [3:0]    s_be;
    logic [31:0]   s_addr, s_wdata;
    logic          s_gnt = 1'b0, s_rvalid = 1'b0;
    logic [31:0]   s_rdata = '0;
    logic          owner, busy;

    int checks = 0;
    int errors = 0;

    riscv_bus_arbiter #(.STARVE_LIMIT(LIMIT), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_instr_req(instr_req), .i_instr_addr(instr_addr),
        .o_instr_gnt(instr_gnt), .o_instr_rvalid(instr_rvalid), .o_instr_rdata(instr_rdata),
        .i_data_req(data_req), .i_data_we(data_we), .i_data_be(data_be),
        .i_data_addr(data_addr), .i_data_wdata(data_wdata),
        .o_data_gnt(data_gnt), .o_data_rvalid(data_rvalid), .o_data_rdata(data_rdata),
        .o_s_req(s_req), .o_s_we(s_we), .o_s_be(s_be), .o_s_addr(s_addr), .o_s_wdata(s_wdata),
        .i_s_gnt(s_gnt), .i_s_rvalid(s_rvalid), .i_s_rdata(s_rdata),
        .o_owner(owner), .o_busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Model: at most one pending transaction, recorded as who owns it and
    // whether the slave has accepted it yet, plus the count of fetch losses.
    bit          m_pend = 0, m_acc = 0, m_own = 0;
    bit          m_we = 0;
    logic [3:0]  m_be = '0;
    logic [31:0] m_addr = '0, m_wdata = '0;
    int          m_losses = 0;

    bit          e_sreq, e_swe, e_igr, e_dgr, e_irv, e_drv;
    logic [3:0]  e_sbe;
    logic [31:0] e_saddr, e_swdata, e_ird, e_drd;

    task automatic model_and_check();
        bit pick_data;
        if (!rst_n) begin
            m_pend = 0; m_acc = 0; m_own = 0; m_losses = 0;
            m_we = 0; m_be = '0; m_addr = '0; m_wdata = '0;
        end
        e_sreq = 0; e_swe = 0; e_sbe = '0; e_saddr = '0; e_swdata = '0;
        e_igr = 0; e_dgr = 0; e_irv = 0; e_drv = 0; e_ird = '0; e_drd = '0;
        check_eq("owner", owner, m_own);
        check_eq("busy", busy, m_pend);
        if (!m_pend) begin
            if (instr_req || data_req) begin
                pick_data = data_req && (m_losses < LIMIT || !instr_req);
                if (pick_data) begin
                    m_we = data_we; m_be = data_be; m_addr = data_addr; m_wdata = data_wdata;
                    if (instr_req) m_losses = (m_losses + 1 > LIMIT) ? LIMIT : m_losses + 1;
                end else begin
                    m_we = 0; m_be = 4'hF; m_addr = instr_addr; m_wdata = '0;
                    if (s_gnt) m_losses = 0;
                end
                e_sreq = 1; e_swe = m_we; e_sbe = m_be; e_saddr = m_addr; e_swdata = m_wdata;
                e_dgr = s_gnt && pick_data;
                e_igr = s_gnt && !pick_data;
                m_own = pick_data; m_pend = 1; m_acc = s_gnt;
            end
        end else if (!m_acc) begin
            e_sreq = 1; e_swe = m_we; e_sbe = m_be; e_saddr = m_addr; e_swdata = m_wdata;
            if (s_gnt) begin
                e_dgr = m_own; e_igr = !m_own; m_acc = 1;
                if (!m_own) m_losses = 0;
            end
        end else if (s_rvalid) begin
            if (m_own) begin e_drv = 1; e_drd = s_rdata; end
            else begin e_irv = 1; e_ird = s_rdata; end
            m_pend = 0; m_acc = 0;
        end
        check_eq("s_req", s_req, e_sreq);
        check_eq("s_we", s_we, e_swe);
        check_eq("s_be", s_be, e_sbe);
        check_eq("s_addr", s_addr, e_saddr);
        check_eq("s_wdata", s_wdata, e_swdata);
        check_eq("instr_gnt", instr_gnt, e_igr);
        check_eq("data_gnt", data_gnt, e_dgr);
        check_eq("instr_rvalid", instr_rvalid, e_irv);
        check_eq("instr_rdata", instr_rdata, e_ird);
        check_eq("data_rvalid", data_rvalid, e_drv);
        check_eq("data_rdata", data_rdata, e_drd);
    endtask

    // Inputs are set at posedge+1; outputs are judged mid-cycle.
    task automatic eval_cycle();
        #2;
        model_and_check();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        instr_req = 0; data_req = 0; data_we = 0; data_be = '0;
        data_addr = '0; data_wdata = '0; instr_addr = '0;
        s_gnt = 0; s_rvalid = 0; s_rdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        eval_cycle();
        tick();
        rst_n = 1;
    endtask

    int n_data;
    bit seen_fetch;

    initial begin
        #1;
        do_reset();

        // Reset state with no traffic.
        eval_cycle();
        check_eq("reset_busy", busy, 0);
        tick();

        // Reset in the middle of a data read, then a late rvalid.
        data_req = 1; data_addr = 32'h40; s_gnt = 1;
        eval_cycle(); check_eq("rst_mid_gnt", data_gnt, 1); tick();
        idle_inputs(); rst_n = 0;
        eval_cycle(); tick();
        rst_n = 1; s_rvalid = 1; s_rdata = 32'hAAAA5555;
        eval_cycle();
        check_eq("rst_mid_busy", busy, 0);
        check_eq("rst_mid_drv", data_rvalid, 0);
        check_eq("rst_mid_irv", instr_rvalid, 0);
        tick();

        // Fetch only, zero-wait slave.
        do_reset();
        instr_req = 1; instr_addr = 32'h100; s_gnt = 1;
        eval_cycle();
        check_eq("fetch_gnt", instr_gnt, 1);
        check_eq("fetch_we", s_we, 0);
        check_eq("fetch_be", s_be, 4'hF);
        check_eq("fetch_addr", s_addr, 32'h100);
        tick();
        idle_inputs(); s_rvalid = 1; s_rdata = 32'h00500093;
        eval_cycle();
        check_eq("fetch_rvalid", instr_rvalid, 1);
        check_eq("fetch_rdata", instr_rdata, 32'h00500093);
        tick();

        // Simultaneous requests: data first, then fetch.
        do_reset();
        instr_req = 1; instr_addr = 32'h104;
        data_req = 1; data_we = 1; data_addr = 32'h2000; data_wdata = 32'hDEADBEEF; data_be = 4'hF;
        s_gnt = 1;
        eval_cycle();
        check_eq("simul_dgnt", data_gnt, 1);
        check_eq("simul_igntx", instr_gnt, 0);
        check_eq("simul_we", s_we, 1);
        tick();
        data_req = 0; s_gnt = 0; s_rvalid = 1;
        eval_cycle(); check_eq("simul_owner", owner, 1); check_eq("simul_wack", data_rvalid, 1); tick();
        s_rvalid = 0; s_gnt = 1;
        eval_cycle(); check_eq("simul_ignt", instr_gnt, 1); check_eq("simul_iaddr", s_addr, 32'h104); tick();
        idle_inputs(); s_rvalid = 1;
        eval_cycle(); tick();

        // Starvation: data always requesting, fetch pending.
        do_reset();
        instr_req = 1; instr_addr = 32'h200;
        data_req = 1; data_addr = 32'h3000; data_we = 0; data_be = 4'hF;
        s_gnt = 1; s_rvalid = 1; s_rdata = 32'h11;
        n_data = 0; seen_fetch = 0;
        for (int c = 0; c < 40 && !seen_fetch; c++) begin
            eval_cycle();
            if (data_gnt) n_data++;
            if (instr_gnt) seen_fetch = 1;
            tick();
        end
        check_eq("starve_seen", seen_fetch, 1);
        check_eq("starve_ndata", n_data, LIMIT);
        instr_req = 0;
        eval_cycle(); tick();
        // Counter cleared: data wins again over a fresh fetch request.
        instr_req = 1;
        eval_cycle(); check_eq("starve_clr", data_gnt, 1); tick();
        idle_inputs(); s_rvalid = 1;
        eval_cycle(); tick();

        // Slave stall with competing fetch.
        do_reset();
        data_req = 1; data_addr = 32'h3000; instr_req = 1; instr_addr = 32'h108;
        for (int c = 0; c < 3; c++) begin
            eval_cycle();
            check_eq("stall_addr", s_addr, 32'h3000);
            check_eq("stall_ignt", instr_gnt, 0);
            tick();
        end
        check_eq("stall_busy", busy, 1);
        s_gnt = 1;
        eval_cycle(); check_eq("stall_dgnt", data_gnt, 1); tick();
        data_req = 0; instr_req = 0; s_gnt = 0; s_rvalid = 1; s_rdata = 32'h12345678;
        eval_cycle();
        check_eq("stall_drd", data_rdata, 32'h12345678);
        check_eq("stall_irv", instr_rvalid, 0);
        tick();

        // Stray rvalid in IDLE, extra gnt in RESP.
        do_reset();
        s_rvalid = 1;
        eval_cycle(); check_eq("stray_rv", data_rvalid | instr_rvalid, 0); check_eq("stray_busy", busy, 0); tick();
        s_rvalid = 0; data_req = 1; data_addr = 32'h44; s_gnt = 1;
        eval_cycle(); tick();
        data_req = 0; s_gnt = 1;
        eval_cycle(); check_eq("xgnt", data_gnt | instr_gnt, 0); tick();
        check_eq("xgnt_busy", busy, 1);
        s_gnt = 0; s_rvalid = 1;
        eval_cycle(); tick();

        // Random traffic with protocol-abiding masters.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (!instr_req || e_igr) begin
                instr_req = ($urandom_range(0, 2) != 0);
                instr_addr = $urandom() & 32'hFFFF_FFFC;
            end
            if (!data_req || e_dgr) begin
                data_req = ($urandom_range(0, 2) != 0);
                data_we = 1'($urandom_range(0, 1));
                data_be = 4'($urandom_range(0, 15));
                data_addr = $urandom();
                data_wdata = $urandom();
            end
            s_gnt = ($urandom_range(0, 2) == 0);
            s_rvalid = ($urandom_range(0, 1) == 0);
            s_rdata = $urandom();
            if (c % 700 == 699) begin
                idle_inputs(); rst_n = 0;
            end
            eval_cycle();
            tick();
            rst_n = 1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
